// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Build option: MUX_SCAN_MSB_FIRST_EN reverses the scan so the word leaves MSB first.
package mux_scan_pkg;

   localparam int unsigned N_IN  = 16;
   localparam int unsigned SEL_W = 4;

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

`ifdef MUX_SCAN_MSB_FIRST_EN
   localparam logic [SEL_W-1:0] SEL_START = SEL_W'(15);
   localparam logic [SEL_W-1:0] SEL_END   = SEL_W'(0);

   function automatic logic [SEL_W-1:0] stepSel(input logic [SEL_W-1:0] sel);
      return sel - 1'b1;
   endfunction
`else
   localparam logic [SEL_W-1:0] SEL_START = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_END   = SEL_W'(15);

   function automatic logic [SEL_W-1:0] stepSel(input logic [SEL_W-1:0] sel);
      return sel + 1'b1;
   endfunction
`endif

endpackage

// File: rtl/mux_scan_dwell_timer.sv
// Dwell counter for the mux scan sequencer: counts 0..DWELL-1 while run is high,
// wrapping to 0 after the terminal count; tick flags the terminal count.
module mux_scan_dwell_timer #(
   parameter int unsigned DWELL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] count_q;

   assign tick = (count_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (run) begin
         count_q <= tick ? '0 : count_q + 1'b1;
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer that loads a word onto the 16:1 mux data bus and walks sel across it,
// flagging each cycle on which the mux output carries a valid serial bit.
// Build option: MUX_SCAN_MSB_FIRST_EN (scan order, see mux_scan_pkg).
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IN-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              abort,
   output logic [N_IN-1:0]   data,
   output logic [SEL_W-1:0]  sel,
   output logic              bit_valid,
   output logic              last,
   output logic              done
);

   if (DWELL == 0 || DWELL > 16) begin : g_bad_dwell
      $error("mux_scan_ctrl: DWELL must be in the range 1..16");
   end

   state_t             state_q;
   logic [N_IN-1:0]    data_q;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   selNext;
   logic               in_ready_q;
   logic               bit_valid_q;
   logic               last_q;
   logic               done_q;
   logic               accept;
   logic               timerRun;
   logic               tick;

   assign accept   = (state_q == IDLE) && in_ready_q && in_valid;
   assign timerRun = accept || ((state_q == SCAN) && !abort && !last_q);
   assign selNext  = bit_valid_q ? stepSel(sel_q) : sel_q;

   // The timer runs one cycle ahead of the scan, so tick predicts the next
   // cycle's dwell position and bit_valid can leave straight from a flop.
   mux_scan_dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (!timerRun),
      .run   (timerRun),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         sel_q       <= SEL_START;
         in_ready_q  <= 1'b1;
         bit_valid_q <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         bit_valid_q <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               sel_q      <= SEL_START;
               in_ready_q <= 1'b1;
               if (accept) begin
                  data_q      <= in_data;
                  in_ready_q  <= 1'b0;
                  bit_valid_q <= tick;
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               if (abort || last_q) begin
                  // An abort drops the done pulse even if it lands on the final bit.
                  state_q    <= IDLE;
                  sel_q      <= SEL_START;
                  in_ready_q <= 1'b1;
                  done_q     <= !abort;
               end else begin
                  sel_q       <= selNext;
                  bit_valid_q <= tick;
                  last_q      <= tick && (selNext == SEL_END);
               end
            end
            default: begin
               state_q    <= IDLE;
               sel_q      <= SEL_START;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign data      = data_q;
   assign sel       = sel_q;
   assign bit_valid = bit_valid_q;
   assign last      = last_q;
   assign done      = done_q;

endmodule
